cp0_npc_unit: RTL and testbench

- Next-PC selection and CP0 exception/interrupt control for the single-cycle CPU.
- Sits directly upstream of the PC register: computes the next program counter each cycle and drives it onto PC data_in.
- Holds the CP0 Status, Cause and EPC registers, latches external interrupts, and redirects fetch to the exception vector or back to EPC on eret.
- The PC register loads every cycle (enable tied high), so npc is consumed on every rising edge.

---
 rtl/cp0_npc_unit.sv | 123 ++++++++++++
 tb/tb_cp0_npc_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/cp0_npc_unit.sv
// Next-PC select plus CP0 Status/Cause/EPC with exception, interrupt and eret redirection.
// npc, intr_ack and cp0_rdata are combinational; CP0 state updates on the rising edge.
module cp0_npc_unit #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0008,
  parameter logic [31:0] PC_INC     = 32'd4
) (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic [31:0] pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        exc_ovf,
  input  logic        exc_unimpl,
  input  logic        exc_syscall,
  input  logic        eret,
  input  logic        intr,
  input  logic        mtc0,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  output logic [31:0] npc,
  output logic        intr_ack
);

  localparam logic [4:0] ADDR_STATUS = 5'd12;
  localparam logic [4:0] ADDR_CAUSE  = 5'd13;
  localparam logic [4:0] ADDR_EPC    = 5'd14;

  localparam logic [4:0] CODE_INT = 5'd0;
  localparam logic [4:0] CODE_SYS = 5'd8;
  localparam logic [4:0] CODE_UNI = 5'd10;
  localparam logic [4:0] CODE_OVF = 5'd12;

  logic [31:0] r_status;
  logic [31:0] r_epc;
  logic [4:0]  r_exc_code;
  logic        r_int_pending;

  logic [31:0] w_pc_inc;
  logic [31:0] w_norm_npc;
  logic        w_take_ovf;
  logic        w_take_uni;
  logic        w_take_sys;
  logic        w_take_exc;
  logic        w_take_eret;
  logic        w_take_int;
  logic        w_trap;
  logic [4:0]  w_code;
  logic [31:0] w_epc;

  assign w_pc_inc   = pc + PC_INC;
  assign w_norm_npc = jump ? jump_target : (branch_taken ? branch_target : w_pc_inc);

  assign w_take_ovf  = exc_ovf     & r_status[3];
  assign w_take_uni  = exc_unimpl  & r_status[2];
  assign w_take_sys  = exc_syscall & r_status[1];
  assign w_take_exc  = w_take_ovf | w_take_uni | w_take_sys;
  assign w_take_eret = eret & ~w_take_exc;
  // eret blocks the interrupt outright, so a pending one waits at least one cycle after return
  assign w_take_int  = r_int_pending & r_status[0] & ~w_take_exc & ~eret;
  assign w_trap      = w_take_exc | w_take_int;

  always_comb begin
    w_code = CODE_INT;
    w_epc  = w_norm_npc;
    if (w_take_ovf) begin
      w_code = CODE_OVF;
      w_epc  = pc;
    end else if (w_take_uni) begin
      w_code = CODE_UNI;
      w_epc  = pc;
    end else if (w_take_sys) begin
      w_code = CODE_SYS;
      w_epc  = w_pc_inc;
    end
  end

  assign npc      = w_trap ? EXC_VECTOR : (w_take_eret ? r_epc : w_norm_npc);
  assign intr_ack = w_take_int;

  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      ADDR_STATUS: cp0_rdata = r_status;
      ADDR_CAUSE:  cp0_rdata = {25'd0, r_exc_code, 2'b00};
      ADDR_EPC:    cp0_rdata = r_epc;
      default:     cp0_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      r_status      <= 32'd0;
      r_epc         <= 32'd0;
      r_exc_code    <= 5'd0;
      r_int_pending <= 1'b0;
    end else begin
      if (mtc0) begin
        case (cp0_addr)
          ADDR_STATUS: r_status   <= cp0_wdata;
          ADDR_CAUSE:  r_exc_code <= cp0_wdata[6:2];
          ADDR_EPC:    r_epc      <= cp0_wdata;
          default:     ;
        endcase
      end
      // event updates come last so they override a colliding mtc0 on the same register
      if (w_trap) begin
        r_status   <= r_status << 4;
        r_exc_code <= w_code;
        r_epc      <= w_epc;
      end else if (w_take_eret) begin
        r_status <= r_status >> 4;
      end
      if (w_take_int)
        r_int_pending <= 1'b0;
      else if (intr)
        r_int_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cp0_npc_unit.sv
// Directed bench for cp0_npc_unit: next-PC selection, exceptions, interrupts, eret and mtc0 collisions.
module tb_cp0_npc_unit;

  logic        Clk = 1'b0;
  logic        Clrn;
  logic [31:0] pc;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        exc_ovf, exc_unimpl, exc_syscall, eret, intr, mtc0;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic [31:0] npc;
  logic        intr_ack;

  int n_pass  = 0;
  int n_total = 0;

  cp0_npc_unit dut (
    .Clk(Clk), .Clrn(Clrn), .pc(pc),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .exc_ovf(exc_ovf), .exc_unimpl(exc_unimpl), .exc_syscall(exc_syscall),
    .eret(eret), .intr(intr), .mtc0(mtc0),
    .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata),
    .npc(npc), .intr_ack(intr_ack)
  );

  always #5 Clk = ~Clk;

  task automatic idle();
    branch_taken = 0; branch_target = 0; jump = 0; jump_target = 0;
    exc_ovf = 0; exc_unimpl = 0; exc_syscall = 0; eret = 0; intr = 0;
    mtc0 = 0; cp0_addr = 0; cp0_wdata = 0;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic write_cp0(input logic [4:0] a, input logic [31:0] d);
    idle();
    mtc0 = 1; cp0_addr = a; cp0_wdata = d;
    tick();
    idle();
  endtask

  task automatic test_reset();
    Clrn = 1'b0; idle(); pc = 32'h0;
    tick(); tick();
    Clrn = 1'b1;
    write_cp0(5'd12, 32'hF);
    write_cp0(5'd14, 32'h123);
    write_cp0(5'd13, 32'h7C);
    #2 Clrn = 1'b0;
    #1;
    cp0_addr = 5'd12; #1;
    n_total++; if (cp0_rdata !== 32'h0) $display("FAIL reset_status got=%h exp=%h", cp0_rdata, 32'h0); else n_pass++;
    cp0_addr = 5'd13; #1;
    n_total++; if (cp0_rdata !== 32'h0) $display("FAIL reset_cause got=%h exp=%h", cp0_rdata, 32'h0); else n_pass++;
    cp0_addr = 5'd14; #1;
    n_total++; if (cp0_rdata !== 32'h0) $display("FAIL reset_epc got=%h exp=%h", cp0_rdata, 32'h0); else n_pass++;
    pc = 32'h100; #1;
    n_total++; if (npc !== 32'h104) $display("FAIL reset_npc got=%h exp=%h", npc, 32'h104); else n_pass++;
    tick();
    Clrn = 1'b1;
    intr = 1; tick(); intr = 0;
    tick();
    pc = 32'h200; #1;
    n_total++; if (intr_ack !== 1'b0) $display("FAIL reset_intr_masked_ack got=%b exp=0", intr_ack); else n_pass++;
    n_total++; if (npc !== 32'h204) $display("FAIL reset_intr_masked_npc got=%h exp=%h", npc, 32'h204); else n_pass++;
    Clrn = 1'b0; tick(); Clrn = 1'b1; tick();
  endtask

  task automatic test_seq_branch();
    idle();
    pc = 32'h40; branch_taken = 1; branch_target = 32'h80; #1;
    n_total++; if (npc !== 32'h80) $display("FAIL branch got=%h exp=%h", npc, 32'h80); else n_pass++;
    jump = 1; jump_target = 32'h1000; #1;
    n_total++; if (npc !== 32'h1000) $display("FAIL jump_over_branch got=%h exp=%h", npc, 32'h1000); else n_pass++;
    idle(); pc = 32'hFFFF_FFFC; #1;
    n_total++; if (npc !== 32'h0) $display("FAIL seq_wrap got=%h exp=%h", npc, 32'h0); else n_pass++;
    pc = 32'h40; #1;
    n_total++; if (npc !== 32'h44) $display("FAIL seq got=%h exp=%h", npc, 32'h44); else n_pass++;
    tick();
  endtask

  task automatic test_syscall();
    write_cp0(5'd12, 32'hF);
    pc = 32'h200; exc_syscall = 1; #1;
    n_total++; if (npc !== 32'h8) $display("FAIL sys_npc got=%h exp=%h", npc, 32'h8); else n_pass++;
    tick(); idle();
    cp0_addr = 5'd14; #1;
    n_total++; if (cp0_rdata !== 32'h204) $display("FAIL sys_epc got=%h exp=%h", cp0_rdata, 32'h204); else n_pass++;
    cp0_addr = 5'd13; #1;
    n_total++; if (cp0_rdata !== 32'h20) $display("FAIL sys_cause got=%h exp=%h", cp0_rdata, 32'h20); else n_pass++;
    cp0_addr = 5'd12; #1;
    n_total++; if (cp0_rdata !== 32'hF0) $display("FAIL sys_status got=%h exp=%h", cp0_rdata, 32'hF0); else n_pass++;
  endtask

  task automatic test_ovf();
    write_cp0(5'd12, 32'hF);
    pc = 32'h300; exc_ovf = 1; exc_syscall = 1; #1;
    n_total++; if (npc !== 32'h8) $display("FAIL ovf_npc got=%h exp=%h", npc, 32'h8); else n_pass++;
    tick(); idle();
    cp0_addr = 5'd14; #1;
    n_total++; if (cp0_rdata !== 32'h300) $display("FAIL ovf_epc got=%h exp=%h", cp0_rdata, 32'h300); else n_pass++;
    cp0_addr = 5'd13; #1;
    n_total++; if (cp0_rdata !== 32'h30) $display("FAIL ovf_cause got=%h exp=%h", cp0_rdata, 32'h30); else n_pass++;
    write_cp0(5'd12, 32'hF);
    pc = 32'h340; exc_unimpl = 1; exc_syscall = 1;
    tick(); idle();
    cp0_addr = 5'd14; #1;
    n_total++; if (cp0_rdata !== 32'h340) $display("FAIL uni_epc got=%h exp=%h", cp0_rdata, 32'h340); else n_pass++;
    cp0_addr = 5'd13; #1;
    n_total++; if (cp0_rdata !== 32'h28) $display("FAIL uni_cause got=%h exp=%h", cp0_rdata, 32'h28); else n_pass++;
    write_cp0(5'd12, 32'h0);
    pc = 32'h400; exc_ovf = 1; #1;
    n_total++; if (npc !== 32'h404) $display("FAIL ovf_masked_npc got=%h exp=%h", npc, 32'h404); else n_pass++;
    tick(); idle();
    cp0_addr = 5'd14; #1;
    n_total++; if (cp0_rdata !== 32'h340) $display("FAIL ovf_masked_epc got=%h exp=%h", cp0_rdata, 32'h340); else n_pass++;
    cp0_addr = 5'd13; #1;
    n_total++; if (cp0_rdata !== 32'h28) $display("FAIL ovf_masked_cause got=%h exp=%h", cp0_rdata, 32'h28); else n_pass++;
    cp0_addr = 5'd12; #1;
    n_total++; if (cp0_rdata !== 32'h0) $display("FAIL ovf_masked_status got=%h exp=%h", cp0_rdata, 32'h0); else n_pass++;
  endtask

  task automatic test_interrupt();
    write_cp0(5'd12, 32'h1);
    pc = 32'h480; intr = 1; #1;
    n_total++; if (intr_ack !== 1'b0) $display("FAIL int_same_cycle_ack got=%b exp=0", intr_ack); else n_pass++;
    n_total++; if (npc !== 32'h484) $display("FAIL int_same_cycle_npc got=%h exp=%h", npc, 32'h484); else n_pass++;
    tick(); idle();
    pc = 32'h500; #1;
    n_total++; if (npc !== 32'h8) $display("FAIL int_npc got=%h exp=%h", npc, 32'h8); else n_pass++;
    n_total++; if (intr_ack !== 1'b1) $display("FAIL int_ack got=%b exp=1", intr_ack); else n_pass++;
    tick();
    pc = 32'h8; cp0_addr = 5'd14; #1;
    n_total++; if (intr_ack !== 1'b0) $display("FAIL int_ack_once got=%b exp=0", intr_ack); else n_pass++;
    n_total++; if (cp0_rdata !== 32'h504) $display("FAIL int_epc got=%h exp=%h", cp0_rdata, 32'h504); else n_pass++;
    cp0_addr = 5'd12; #1;
    n_total++; if (cp0_rdata !== 32'h10) $display("FAIL int_status got=%h exp=%h", cp0_rdata, 32'h10); else n_pass++;
    cp0_addr = 5'd13; #1;
    n_total++; if (cp0_rdata !== 32'h0) $display("FAIL int_cause got=%h exp=%h", cp0_rdata, 32'h0); else n_pass++;
    intr = 1; tick(); intr = 0;
    pc = 32'h10; #1;
    n_total++; if (intr_ack !== 1'b0) $display("FAIL int_held_ack got=%b exp=0", intr_ack); else n_pass++;
    n_total++; if (npc !== 32'h14) $display("FAIL int_held_npc got=%h exp=%h", npc, 32'h14); else n_pass++;
    tick();
    pc = 32'h14; eret = 1; #1;
    n_total++; if (npc !== 32'h504) $display("FAIL eret_npc got=%h exp=%h", npc, 32'h504); else n_pass++;
    n_total++; if (intr_ack !== 1'b0) $display("FAIL eret_no_int got=%b exp=0", intr_ack); else n_pass++;
    tick(); eret = 0;
    cp0_addr = 5'd12; pc = 32'h504; #1;
    n_total++; if (cp0_rdata !== 32'h1) $display("FAIL eret_status got=%h exp=%h", cp0_rdata, 32'h1); else n_pass++;
    n_total++; if (npc !== 32'h8) $display("FAIL int2_npc got=%h exp=%h", npc, 32'h8); else n_pass++;
    n_total++; if (intr_ack !== 1'b1) $display("FAIL int2_ack got=%b exp=1", intr_ack); else n_pass++;
    tick(); idle();
    cp0_addr = 5'd14; #1;
    n_total++; if (cp0_rdata !== 32'h508) $display("FAIL int2_epc got=%h exp=%h", cp0_rdata, 32'h508); else n_pass++;
  endtask

  task automatic test_collision();
    write_cp0(5'd12, 32'hF);
    pc = 32'h10; exc_syscall = 1; mtc0 = 1; cp0_addr = 5'd14; cp0_wdata = 32'hABC; #1;
    n_total++; if (npc !== 32'h8) $display("FAIL coll_sys_npc got=%h exp=%h", npc, 32'h8); else n_pass++;
    tick(); idle();
    cp0_addr = 5'd14; #1;
    n_total++; if (cp0_rdata !== 32'h14) $display("FAIL coll_epc got=%h exp=%h", cp0_rdata, 32'h14); else n_pass++;
    pc = 32'h8; eret = 1; mtc0 = 1; cp0_addr = 5'd12; cp0_wdata = 32'hFFFF; #1;
    n_total++; if (npc !== 32'h14) $display("FAIL coll_eret_npc got=%h exp=%h", npc, 32'h14); else n_pass++;
    tick(); idle();
    cp0_addr = 5'd12; #1;
    n_total++; if (cp0_rdata !== 32'hF) $display("FAIL coll_eret_status got=%h exp=%h", cp0_rdata, 32'hF); else n_pass++;
    eret = 1; mtc0 = 1; cp0_addr = 5'd14; cp0_wdata = 32'h777;
    tick(); idle();
    cp0_addr = 5'd14; #1;
    n_total++; if (cp0_rdata !== 32'h777) $display("FAIL coll_eret_epc_lands got=%h exp=%h", cp0_rdata, 32'h777); else n_pass++;
    cp0_addr = 5'd12; #1;
    n_total++; if (cp0_rdata !== 32'h0) $display("FAIL coll_eret_status2 got=%h exp=%h", cp0_rdata, 32'h0); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_seq_branch();
    test_syscall();
    test_ovf();
    test_interrupt();
    test_collision();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
